// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//
// Multi-cycle unsigned magnitude comparator. The operands are captured on an
// accepted start and examined two bits per cycle, most significant pair
// first. The first unequal pair decides the result. If every pair matches,
// the operands are equal. Wide words reuse a single 2-bit compare per cycle
// instead of needing a flat WIDTH-bit comparator.
//
// Parameters
//   WIDTH        operand width in bits (even, >= 2); P = WIDTH/2 pairs
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request a comparison (sampled only while idle)
//   a, b         in   WIDTH-bit unsigned operands, captured on accept
//   busy         out  comparison in progress
//   done         out  one-cycle pulse, result flags valid
//   a_less_b     out  result flag A < B
//   a_equal_b    out  result flag A = B
//   a_greater_b  out  result flag A > B
//
// The result flags are one-hot after done. They hold until the next
// accepted start clears them.

module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_less_b,
    output logic             a_equal_b,
    output logic             a_greater_b
);

    localparam int P     = WIDTH / 2;
    localparam int CNT_W = $clog2(P) + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;

    // The pair currently under test always sits at the top of the shift
    // registers.
    logic [1:0] a_hi;
    logic [1:0] b_hi;

    assign a_hi = a_sh_q[WIDTH-1 -: 2];
    assign b_hi = b_sh_q[WIDTH-1 -: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;

        case (state_q)
            IDLE: begin
                // An accept is possible in the done cycle too, which gives
                // back-to-back comparisons with no idle gap.
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = CNT_W'(P);
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (a_hi > b_hi) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (a_hi < b_hi) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    // Last pair matched, so the whole word is equal.
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    a_sh_d  = a_sh_q << 2;
                    b_sh_d  = b_sh_q << 2;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign a_less_b    = lt_q;
    assign a_equal_b   = eq_q;
    assign a_greater_b = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_less_b;
    logic             a_equal_b;
    logic             a_greater_b;

    int checks;
    int errors;

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .a_less_b    (a_less_b),
        .a_equal_b   (a_equal_b),
        .a_greater_b (a_greater_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        int         lat;
        logic       lt;
        logic       eq;
        logic       gt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {a_less_b, a_equal_b, a_greater_b};
    endfunction

    // Accept one comparison, then follow it to done, checking latency,
    // busy, flags and the one-cycle done pulse.
    task automatic run_vec(input string name, input logic [7:0] va, input logic [7:0] vb,
                           input int lat, input logic [2:0] exp_flags);
        int  n;
        bit  busy_ok;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va;
        b = ~vb;
        chk({name, "_accept_busy"}, 32'(busy), 32'd1);
        chk({name, "_accept_flags"}, 32'(flags()), 32'd0);
        busy_ok = 1'b1;
        n = 0;
        while (n < 12) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_busy_before_done"}, 32'(busy_ok), 32'd1);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({name, "_flags"}, 32'(flags()), 32'(exp_flags));
        @(posedge clk);
        #1;
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_flags_hold"}, 32'(flags()), 32'(exp_flags));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        //            a      b      lat lt eq gt
        vecs[0] = '{8'hA5, 8'hA5, 4, 0, 1, 0};
        vecs[1] = '{8'h80, 8'h7F, 1, 0, 0, 1};
        vecs[2] = '{8'h34, 8'h35, 4, 1, 0, 0};
        vecs[3] = '{8'h40, 8'h80, 1, 1, 0, 0};
        vecs[4] = '{8'h01, 8'h00, 4, 0, 0, 1};
        vecs[5] = '{8'h00, 8'h00, 4, 0, 1, 0};
        vecs[6] = '{8'hFF, 8'hFE, 4, 0, 0, 1};
        vecs[7] = '{8'hC0, 8'hF0, 2, 1, 0, 0};
        vecs[8] = '{8'h0C, 8'h08, 3, 0, 0, 1};
        vecs[9] = '{8'hFF, 8'h00, 1, 0, 0, 1};

        // Reset held with start asserted: nothing may move.
        start = 1'b1;
        a = 8'h12;
        b = 8'h34;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'(flags()), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].lat,
                    {vecs[i].lt, vecs[i].eq, vecs[i].gt});
        end

        // start during COMPARE is ignored; then back-to-back accept in the done cycle.
        @(negedge clk);
        a = 8'h34;
        b = 8'h35;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_busy_e2", 32'(busy), 32'd1);
        chk("ign_flags_e2", 32'(flags()), 32'd0);
        @(posedge clk);
        #1;
        chk("ign_done_e3", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("ign_done_e4", 32'(done), 32'd1);
        chk("ign_flags_e4", 32'(flags()), 32'b100);
        a = 8'h40;
        b = 8'h80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        chk("b2b_flags_cleared", 32'(flags()), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_result_done", 32'(done), 32'd1);
        chk("b2b_result_flags", 32'(flags()), 32'b100);

        // Reset mid-comparison aborts it with no done pulse.
        @(negedge clk);
        a = 8'hA5;
        b = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", 32'(flags()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_done_later", 32'(done), 32'd0);
        chk("abort_flags_later", 32'(flags()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_abort", 8'h01, 8'h00, 4, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
